// File: rtl/mul_fifo_driver_if.sv
// Handshake bundle between the self-test driver and the kadai3 square-through-FIFO datapath.
interface mul_fifo_driver_if #(
    parameter int DATA_W = 16
);
    logic              write;
    logic              read;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              empty;
    logic              full;
    logic              valid;

    modport master (
        output write, read, din,
        input  dout, empty, full, valid
    );

    modport slave (
        input  write, read, din,
        output dout, empty, full, valid
    );
endinterface

// File: rtl/mul_fifo_driver.sv
// Self-checking initiator for kadai3: writes {idx,idx}, expects idx*idx back, counts passes/errors.
//
// state   | meaning
// IDLE    | waiting for start after reset
// DECIDE  | pick write/read for the next slot from the LFSR, or go to DRAIN
// WR      | write strobe high, expected square pushed
// WR_GAP  | idle cycle after write, idx advances
// RD      | read strobe high
// RD_WAIT | waiting up to TIMEOUT cycles for valid, then compare/pop
// DRAIN   | all slots used; read back remaining expected entries
// DONE    | run finished; counters hold until the next start
module mul_fifo_driver #(
    parameter int          DATA_W    = 16,
    parameter int          NUM_OPS   = 100,
    parameter int          START_IDX = 2,
    parameter int          EXP_DEPTH = 16,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    mul_fifo_driver_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          err_cnt,
    output logic                 err
);

    localparam int BYTE_W = DATA_W / 2;
    localparam int AW     = $clog2(EXP_DEPTH);
    localparam int SLOT_W = $clog2(NUM_OPS + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(NUM_OPS);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT - 1);
    localparam logic [AW:0]       Q_CAP     = (AW + 1)'(EXP_DEPTH);
    localparam logic [BYTE_W-1:0] IDX_INIT  = BYTE_W'(START_IDX);

    typedef enum logic [2:0] {
        IDLE, DECIDE, WR, WR_GAP, RD, RD_WAIT, DRAIN, DONE
    } state_t;

    state_t             state;
    logic [BYTE_W-1:0]  idx;
    logic [15:0]        lfsr;
    logic [SLOT_W-1:0]  slot;
    logic [TO_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]  q_mem [EXP_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        q_cnt;

    logic [15:0]        lfsr_nxt;
    logic [DATA_W-1:0]  idx_sq;
    logic [DATA_W-1:0]  q_head;
    logic               q_full;
    logic               q_empty;

    // Fibonacci LFSR, taps 16,14,13,11; the fresh bit0 selects read (1) or write (0)
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign idx_sq   = {{BYTE_W{1'b0}}, idx} * {{BYTE_W{1'b0}}, idx};
    assign q_head   = q_mem[rd_ptr];
    assign q_full   = (q_cnt == Q_CAP);
    assign q_empty  = (q_cnt == '0);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [AW:0] n);
        logic [16:0] s;
        s = {1'b0, v} + {{(16 - AW){1'b0}}, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (state == WR) begin
            q_mem[wr_ptr] <= idx_sq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= IDX_INIT;
            lfsr      <= LFSR_SEED;
            slot      <= '0;
            wait_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            bus.write <= 1'b0;
            bus.read  <= 1'b0;
            bus.din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            bus.write <= 1'b0;
            bus.read  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= DECIDE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass_cnt <= '0;
                        err_cnt  <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        q_cnt    <= '0;
                        slot     <= '0;
                    end
                end
                DECIDE: begin
                    if (slot == SLOT_END) begin
                        state    <= DRAIN;
                        wait_cnt <= TO_LOAD;
                    end else begin
                        lfsr <= lfsr_nxt;
                        slot <= slot + 1'b1;
                        // a blocked choice burns the slot and we decide again next cycle
                        if (!lfsr_nxt[0]) begin
                            if (!bus.full && !q_full) begin
                                state     <= WR;
                                bus.write <= 1'b1;
                                bus.din   <= {idx, idx};
                            end
                        end else if (!bus.empty && !q_empty) begin
                            state    <= RD;
                            bus.read <= 1'b1;
                        end
                    end
                end
                WR: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    q_cnt  <= q_cnt + 1'b1;
                    state  <= WR_GAP;
                end
                WR_GAP: begin
                    idx   <= idx + 1'b1;
                    state <= DECIDE;
                end
                RD: begin
                    wait_cnt <= TO_LOAD;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.valid) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        q_cnt  <= q_cnt - 1'b1;
                        state  <= DECIDE;
                        if (bus.dout == q_head) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                            err     <= 1'b1;
                        end
                    end else if (wait_cnt == '0) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        q_cnt   <= q_cnt - 1'b1;
                        err_cnt <= sat_inc(err_cnt);
                        err     <= 1'b1;
                        state   <= DECIDE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (q_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!bus.empty) begin
                        state    <= RD;
                        bus.read <= 1'b1;
                    end else if (wait_cnt == '0) begin
                        // datapath lost results: every outstanding expectation is an error
                        err_cnt <= sat_add(err_cnt, q_cnt);
                        err     <= 1'b1;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        q_cnt   <= '0;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fifo_driver.sv
// Bench for mul_fifo_driver against a behavioural kadai3 model with random read latency and back-pressure.
module tb_mul_fifo_driver;
    localparam int DATA_W    = 16;
    localparam int NUM_OPS   = 100;
    localparam int START_IDX = 2;
    localparam int EXP_DEPTH = 16;
    localparam int TIMEOUT   = 15;
    localparam int M_DEPTH   = 8;
    localparam int RUN_MAX   = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] pass_cnt, err_cnt;

    mul_fifo_driver_if #(.DATA_W(DATA_W)) bus ();

    mul_fifo_driver #(
        .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .START_IDX(START_IDX),
        .EXP_DEPTH(EXP_DEPTH), .TIMEOUT(TIMEOUT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // kadai3 model: one result queue standing in for fifo1 -> square -> fifo2
    logic [15:0] kq[$];
    int          m_cnt;
    int          lat_max = 1;
    bit          force_full = 1'b0;
    bit          rnd_full_en = 1'b0;
    logic        rnd_full;
    int          corrupt_req = 0, corrupt_ack = 0;
    int          drop_req = 0, drop_ack = 0;
    int          pend_cd, m_d;
    bit          pend_live;
    logic [15:0] pend_val;

    function automatic logic [15:0] sq(input logic [15:0] d);
        return 16'(d[15:8]) * 16'(d[7:0]);
    endfunction

    assign bus.empty = (m_cnt == 0);
    assign bus.full  = force_full || rnd_full || (m_cnt >= M_DEPTH);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            kq.delete();
            m_cnt     <= 0;
            bus.valid <= 1'b0;
            bus.dout  <= '0;
            rnd_full  <= 1'b0;
            pend_live = 1'b0;
        end else begin
            m_d = 0;
            bus.valid <= 1'b0;
            rnd_full  <= rnd_full_en && ($urandom_range(0, 3) == 0);
            if (bus.write) begin
                kq.push_back(sq(bus.din));
                m_d++;
            end
            if (bus.read && kq.size() > 0) begin
                pend_val = kq.pop_front();
                m_d--;
                if (corrupt_req != corrupt_ack && pend_val == 16'h0004) begin
                    pend_val    = 16'h0005;
                    corrupt_ack = corrupt_req;
                end
                if (drop_req != drop_ack) begin
                    drop_ack  = drop_req;
                    pend_live = 1'b0;
                end else begin
                    pend_live = 1'b1;
                    pend_cd   = $urandom_range(1, lat_max);
                end
            end
            if (pend_live) begin
                pend_cd--;
                if (pend_cd == 0) begin
                    bus.valid <= 1'b1;
                    bus.dout  <= pend_val;
                    pend_live = 1'b0;
                end
            end
            m_cnt <= m_cnt + m_d;
        end
    end

    // observer: expected din sequence, strobe rules, err pulse timing
    int         cyc = 0, n_wr = 0, n_rd = 0, n_err = 0, din_bad = 0, strobe_bad = 0;
    int         last_rd_cyc = 0, err_gap = 0, wrap_seen = 0;
    logic [7:0] e_idx = 8'(START_IDX);
    bit         want_zero = 1'b0;
    logic       prev_wr = 1'b0, prev_rd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            e_idx     = 8'(START_IDX);
            want_zero = 1'b0;
            prev_wr   = 1'b0;
            prev_rd   = 1'b0;
        end else begin
            if (bus.write && bus.read) strobe_bad++;
            if ((bus.write || bus.read) && (prev_wr || prev_rd)) strobe_bad++;
            if (bus.write) begin
                if (bus.din !== {e_idx, e_idx}) din_bad++;
                if (want_zero && bus.din === 16'h0000) wrap_seen++;
                want_zero = (bus.din === 16'hFFFF);
                e_idx++;
                n_wr++;
            end
            if (bus.read) begin
                n_rd++;
                last_rd_cyc = cyc;
            end
            if (err) begin
                n_err++;
                err_gap = cyc - last_rd_cyc;
            end
            prev_wr = bus.write;
            prev_rd = bus.read;
        end
    end

    int checks = 0, passed = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag);
        int n;
        n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!done && n < RUN_MAX) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
    endtask

    int w0, e0, d0, s0, writes, n;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.write, bus.read, busy, done, err, pass_cnt, err_cnt}, 64'd0);
        chk("reset_din", 64'(bus.din), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: random latency and back-pressure, everything written must come back right
        lat_max = 4; rnd_full_en = 1'b1;
        w0 = n_wr; e0 = n_err; d0 = din_bad; s0 = strobe_bad;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("t1_busy_after_start", {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < RUN_MAX) begin
            @(negedge clk);
            n++;
        end
        chk("t1_done", {63'd0, done}, 64'd1);
        writes = n_wr - w0;
        chk("t1_some_writes", 64'(writes > 0), 64'd1);
        chk("t1_pass_cnt", 64'(pass_cnt), 64'(writes));
        chk("t1_err_cnt", 64'(err_cnt), 64'd0);
        chk("t1_err_pulses", 64'(n_err - e0), 64'd0);
        chk("t1_busy_idle", {63'd0, busy}, 64'd0);
        chk("t1_din_seq", 64'(din_bad - d0), 64'd0);
        chk("t1_strobes", 64'(strobe_bad - s0), 64'd0);

        // 2: input FIFO reports full for the whole run
        force_full = 1'b1; rnd_full_en = 1'b0;
        w0 = n_wr;
        run("t2");
        chk("t2_writes", 64'(n_wr - w0), 64'd0);
        chk("t2_counts", {32'd0, pass_cnt, err_cnt}, 64'd0);
        force_full = 1'b0;

        // 3: first result for idx=2 comes back as 5 instead of 4
        pulse_reset();
        corrupt_req++;
        w0 = n_wr; e0 = n_err;
        run("t3");
        writes = n_wr - w0;
        chk("t3_err_pulses", 64'(n_err - e0), 64'd1);
        chk("t3_err_cnt", 64'(err_cnt), 64'd1);
        chk("t3_pass_cnt", 64'(pass_cnt), 64'(writes - 1));

        // 4: first read gets no valid at all
        pulse_reset();
        drop_req++;
        w0 = n_wr; e0 = n_err;
        run("t4");
        writes = n_wr - w0;
        chk("t4_err_pulses", 64'(n_err - e0), 64'd1);
        chk("t4_err_gap", 64'(err_gap), 64'(TIMEOUT + 1));
        chk("t4_err_cnt", 64'(err_cnt), 64'd1);
        chk("t4_pass_cnt", 64'(pass_cnt), 64'(writes - 1));

        // 5: reset lands in the gap cycle after a write
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!bus.write && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_saw_write", {63'd0, bus.write}, 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("t5_async_clear", {bus.write, bus.read, busy, done, err, pass_cnt, err_cnt}, 64'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!bus.write && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_restart_din", 64'(bus.din), 64'h0202);
        n = 0;
        while (!done && n < RUN_MAX) begin
            @(negedge clk);
            n++;
        end
        chk("t5_done", {63'd0, done}, 64'd1);

        // 6: keep running until idx wraps 255 -> 0
        pulse_reset();
        lat_max = 1;
        w0 = wrap_seen; e0 = n_err; d0 = din_bad;
        for (int r = 0; r < 20 && wrap_seen == w0; r++) begin
            run("t6");
        end
        chk("t6_wrap_seen", 64'(wrap_seen - w0), 64'd1);
        chk("t6_last_err_cnt", 64'(err_cnt), 64'd0);
        chk("t6_err_pulses", 64'(n_err - e0), 64'd0);
        chk("t6_din_seq", 64'(din_bad - d0), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
